// File: rtl/infrared_conditioner.sv
// rtl/infrared_conditioner.sv - sync, debounce and tail/line-lost conditioning of the IR sensors.
// Optional LINE_LOST_HOLD_EN: hold last non-zero pattern for LOST_HOLD sample ticks before reporting loss.
module infrared_conditioner #(
  parameter int CLK_DIV   = 5000,
  parameter int DEB_LEN   = 4,
  parameter int TAIL_LEN  = 16,
  parameter int LOST_HOLD = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic left_infrared,
  input  logic mid_left_infrared,
  input  logic mid_right_infrared,
  input  logic right_infrared,
  input  logic tail,
  output logic left_infrared_f,
  output logic mid_left_infrared_f,
  output logic mid_right_infrared_f,
  output logic right_infrared_f,
  output logic tail_stop,
  output logic line_lost,
  output logic sensor_change,
  output logic sample_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DEB_LEN + 1);
  localparam int TW = $clog2(TAIL_LEN + 1);

  if (CLK_DIV < 2 || DEB_LEN < 1 || TAIL_LEN < 1 || LOST_HOLD < 1) begin : g_bad_params
    $error("infrared_conditioner: illegal parameter value");
  end

  // bit 4 is the tail sensor; bits 3..0 are the track pattern, left at the top
  logic [4:0]    sync1, sync2;
  logic [PW-1:0] presc;
  logic [3:0]    filt, filt_next;
  logic [3:0]    pres, pres_next;
  logic [DW-1:0] dcnt [4];
  logic [DW-1:0] dcnt_next [4];
  logic [TW-1:0] tail_cnt;

  always_comb begin
    filt_next = filt;
    for (int i = 0; i < 4; i++) begin
      dcnt_next[i] = dcnt[i];
      if (sample_tick) begin
        if (sync2[i] != filt[i]) begin
          if (dcnt[i] == DW'(DEB_LEN - 1)) begin
            filt_next[i] = ~filt[i];
            dcnt_next[i] = '0;
          end else begin
            dcnt_next[i] = dcnt[i] + DW'(1);
          end
        end else begin
          dcnt_next[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      presc         <= '0;
      sample_tick   <= 1'b0;
      filt          <= '0;
      pres          <= '0;
      tail_cnt      <= '0;
      tail_stop     <= 1'b0;
      line_lost     <= 1'b0;
      sensor_change <= 1'b0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= {tail, left_infrared, mid_left_infrared, mid_right_infrared, right_infrared};
      sync2 <= sync1;
      if (presc == PW'(CLK_DIV - 1)) presc <= '0;
      else                           presc <= presc + PW'(1);
      sample_tick <= (presc == PW'(CLK_DIV - 1));
      filt <= filt_next;
      for (int i = 0; i < 4; i++) dcnt[i] <= dcnt_next[i];
      // line_lost and the change strobe are registered alongside the pattern they describe
      pres          <= pres_next;
      line_lost     <= ~|pres_next;
      sensor_change <= (pres_next != pres);
      if (sample_tick && !tail_stop) begin
        if (sync2[4]) begin
          if (tail_cnt == TW'(TAIL_LEN - 1)) begin
            tail_stop <= 1'b1;
            tail_cnt  <= TW'(TAIL_LEN);
          end else begin
            tail_cnt <= tail_cnt + TW'(1);
          end
        end else begin
          tail_cnt <= '0;
        end
      end
    end
  end

`ifdef LINE_LOST_HOLD_EN
  localparam int HW = $clog2(LOST_HOLD + 1);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    pres_next  = pres;
    case (state)
      IDLE: begin
        pres_next = filt_next;
        if (filt_next == 4'b0000 && pres != 4'b0000) begin
          pres_next  = pres;
          state_next = HOLD;
          hold_next  = '0;
        end
      end
      HOLD: begin
        // the tick that caused entry is not counted; only later ticks age the hold
        if (filt_next != 4'b0000) begin
          pres_next  = filt_next;
          state_next = IDLE;
          hold_next  = '0;
        end else if (sample_tick) begin
          if (hold_cnt == HW'(LOST_HOLD - 1)) begin
            pres_next  = 4'b0000;
            state_next = IDLE;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  assign pres_next = filt_next;
`endif

  assign left_infrared_f      = pres[3];
  assign mid_left_infrared_f  = pres[2];
  assign mid_right_infrared_f = pres[1];
  assign right_infrared_f     = pres[0];

endmodule

// File: tb/tb_infrared_conditioner.sv
// tb/tb_infrared_conditioner.sv - directed bench with a pattern-change scoreboard for infrared_conditioner.
module tb_infrared_conditioner;
  localparam int CLK_DIV   = 4;
  localparam int DEB_LEN   = 3;
  localparam int TAIL_LEN  = 5;
  localparam int LOST_HOLD = 2;

  logic clk, rst;
  logic left_infrared, mid_left_infrared, mid_right_infrared, right_infrared, tail;
  logic left_infrared_f, mid_left_infrared_f, mid_right_infrared_f, right_infrared_f;
  logic tail_stop, line_lost, sensor_change, sample_tick;
  logic [3:0] pat;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  infrared_conditioner #(
    .CLK_DIV(CLK_DIV), .DEB_LEN(DEB_LEN), .TAIL_LEN(TAIL_LEN), .LOST_HOLD(LOST_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .left_infrared(left_infrared), .mid_left_infrared(mid_left_infrared),
    .mid_right_infrared(mid_right_infrared), .right_infrared(right_infrared), .tail(tail),
    .left_infrared_f(left_infrared_f), .mid_left_infrared_f(mid_left_infrared_f),
    .mid_right_infrared_f(mid_right_infrared_f), .right_infrared_f(right_infrared_f),
    .tail_stop(tail_stop), .line_lost(line_lost), .sensor_change(sensor_change),
    .sample_tick(sample_tick)
  );

  assign pat = {left_infrared_f, mid_left_infrared_f, mid_right_infrared_f, right_infrared_f};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV && !seen; i++) begin
      @(negedge clk);
      seen = sample_tick;
    end
    check("tick_timeout", seen, 1);
  endtask

  // every sensor_change pulse must match the next expected {pattern, line_lost}
  always @(negedge clk) begin
    if (sensor_change) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_change observed=%0h expected=none", {pat, line_lost});
      end
      if (exp_q.size() != 0) check("scoreboard_change", {pat, line_lost}, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    left_infrared = 1'b1; mid_left_infrared = 1'b1; mid_right_infrared = 1'b1;
    right_infrared = 1'b1; tail = 1'b1;
    repeat (3) begin
      step();
      check("reset_outputs", {pat, tail_stop, line_lost, sensor_change, sample_tick}, 0);
    end

    // release: only left stays high
    rst = 1'b0;
    mid_left_infrared = 1'b0; mid_right_infrared = 1'b0; right_infrared = 1'b0; tail = 1'b0;
    n = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      n++;
      seen = sample_tick;
    end
    check("first_tick_cycle", n, CLK_DIV + 1);
    check("line_lost_idle", line_lost, 1);
    exp_q.push_back({4'b1000, 1'b0});
    tick(); tick();
    check("left_before_3rd_tick", left_infrared_f, 0);
    step();
    check("left_after_3rd_tick", {pat, line_lost}, {4'b1000, 1'b0});
    step();
    check("single_pulse", sensor_change, 0);

    // glitch of two sample periods on mid_left
    tick();
    mid_left_infrared = 1'b1;
    tick(); tick();
    mid_left_infrared = 1'b0;
    tick(); tick(); tick();
    check("glitch_rejected", pat, 4'b1000);

    // left drops: pattern 1000 -> 0000
    left_infrared = 1'b0;
    exp_q.push_back({4'b0000, 1'b1});
    tick(); tick(); tick();
    check("left_still_high", left_infrared_f, 1);
    step();
`ifdef LINE_LOST_HOLD_EN
    check("hold_1000", {pat, line_lost}, {4'b1000, 1'b0});
    tick(); tick(); step();
`endif
    check("line_lost_1000", {pat, line_lost}, {4'b0000, 1'b1});

    // all four rise together
    tick();
    left_infrared = 1'b1; mid_left_infrared = 1'b1; mid_right_infrared = 1'b1; right_infrared = 1'b1;
    exp_q.push_back({4'b1111, 1'b0});
    tick(); tick(); tick();
    check("simul_before", {pat, line_lost}, {4'b0000, 1'b1});
    step();
    check("simul_after", {pat, line_lost, sensor_change}, {4'b1111, 1'b0, 1'b1});

    // pattern 0100 then 0000
    tick();
    left_infrared = 1'b0; mid_right_infrared = 1'b0; right_infrared = 1'b0;
    exp_q.push_back({4'b0100, 1'b0});
    tick(); tick(); tick(); step();
    check("pattern_0100", {pat, line_lost}, {4'b0100, 1'b0});
    tick();
    mid_left_infrared = 1'b0;
    exp_q.push_back({4'b0000, 1'b1});
    tick(); tick(); tick(); step();
`ifdef LINE_LOST_HOLD_EN
    check("hold_0100", {pat, line_lost}, {4'b0100, 1'b0});
    tick(); tick(); step();
`endif
    check("line_lost_0100", {pat, line_lost}, {4'b0000, 1'b1});

`ifdef LINE_LOST_HOLD_EN
    // 0010 re-applied while 0100 is being held
    tick();
    mid_left_infrared = 1'b1;
    exp_q.push_back({4'b0100, 1'b0});
    tick(); tick(); tick(); step();
    check("pattern_0100_again", {pat, line_lost}, {4'b0100, 1'b0});
    tick();
    mid_left_infrared = 1'b0;
    tick();
    mid_right_infrared = 1'b1;
    exp_q.push_back({4'b0010, 1'b0});
    tick(); tick(); step();
    check("held_during_abort", {pat, line_lost}, {4'b0100, 1'b0});
    tick(); step();
    check("abort_to_0010", {pat, line_lost}, {4'b0010, 1'b0});
`endif

    // tail: 4 ones, 1 zero, then 5 ones
    tick();
    tail = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("tail_first_run", tail_stop, 0);
    end
    tail = 1'b0;
    tick();
    tail = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      tick();
      check("tail_second_run", tail_stop, 0);
    end
    step();
    check("tail_stop_set", tail_stop, 1);
    tail = 1'b0;
    tick(); tick(); tick();
    check("tail_stop_sticky", tail_stop, 1);

    // right debouncing interrupted by reset after two ticks
    tick();
    left_infrared = 1'b0; mid_left_infrared = 1'b0; mid_right_infrared = 1'b0; tail = 1'b0;
    right_infrared = 1'b1;
    tick(); tick(); step();
    rst = 1'b1;
    repeat (2) begin
      step();
      check("midreset_outputs", {pat, tail_stop, line_lost, sensor_change, sample_tick}, 0);
    end
    rst = 1'b0;
    exp_q.push_back({4'b0001, 1'b0});
    tick(); tick(); tick();
    check("right_needs_full_count", right_infrared_f, 0);
    step();
    check("right_after_3_ticks", {pat, line_lost}, {4'b0001, 1'b0});

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/infrared_conditioner.md
Name: infrared_conditioner

Overview:
- Front-end stage that sits directly upstream of the line-following steering/wheel PWM controller.
- Synchronises the four track infrared sensors and the tail sensor, then debounces each one on a slow sample tick.
- Produces glitch-free sensor levels, a sticky tail-stop flag, a line-lost flag and a pattern-change strobe.
- The PWM controller consumes these outputs in place of the raw pins.

Parameters:
- CLK_DIV, 5000: clk cycles per sample tick (10 kHz at 50 MHz). Legal range is 2 or more.
- DEB_LEN, 4: number of consecutive disagreeing samples needed to flip a filtered sensor output. Legal range is 1 or more.
- TAIL_LEN, 16: number of consecutive tail=1 samples needed to set tail_stop. Legal range is 1 or more.
- LOST_HOLD, 200: sample ticks that the last non-zero pattern is held. Used only with LINE_LOST_HOLD_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- left_infrared  in  1  raw left sensor, asynchronous
- mid_left_infrared  in  1  raw mid-left sensor, asynchronous
- mid_right_infrared  in  1  raw mid-right sensor, asynchronous
- right_infrared  in  1  raw right sensor, asynchronous
- tail  in  1  raw tail/finish sensor, asynchronous
- left_infrared_f  out  1  filtered left level
- mid_left_infrared_f  out  1  filtered mid-left level
- mid_right_infrared_f  out  1  filtered mid-right level
- right_infrared_f  out  1  filtered right level
- tail_stop  out  1  sticky finish flag
- line_lost  out  1  high while the presented pattern is 0000
- sensor_change  out  1  one-cycle strobe on any presented-pattern change
- sample_tick  out  1  one-cycle strobe, CLK_DIV period, for downstream use

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All registers are cleared on the rst edge.
- Reset values: all outputs 0, prescaler 0, debounce/tail/hold counters 0, synchroniser flops 0.
- rst asserted mid-operation aborts any count in progress. tail_stop is cleared only by rst.
- Synchroniser: two-flop synchroniser on each of the 5 raw inputs. Filter decisions use only the second flop.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. sample_tick is registered and high for exactly the one cycle after the count equals CLK_DIV-1. First tick occurs CLK_DIV+1 cycles after rst release.
- Debounce, one per channel, acting only on sample_tick:
  - If sync != filtered, the counter increments.
  - When the counter would reach DEB_LEN, the filtered output toggles and the counter clears.
  - If sync == filtered, the counter clears.
  - A glitch shorter than DEB_LEN samples never reaches the output.
  - Latency from a stable raw change is 2 clk plus DEB_LEN sample ticks, with the output registered on the DEB_LEN-th tick edge.
- Tail:
  - Counter increments on each tick with tail sync=1 and clears on any tick with 0.
  - When TAIL_LEN consecutive 1s are seen, tail_stop is set and holds until rst; further tail activity is ignored.
  - The counter saturates and never wraps.
- line_lost: registered, equals NOR of the four presented outputs.
- sensor_change: high for exactly the first clk cycle in which the new presented pattern is visible. Several channels changing on the same tick produce a single pulse. No pulse is generated on reset exit.
- Width rules:
  - Prescaler is $clog2(CLK_DIV) bits.
  - Debounce counters are $clog2(DEB_LEN+1) bits.
  - Tail counter is $clog2(TAIL_LEN+1) bits.
  - Hold counter is $clog2(LOST_HOLD+1) bits.
  - All comparisons are unsigned.

Optional Feature:
- Macro: LINE_LOST_HOLD_EN.
- Without the macro: the presented pattern equals the debounced pattern, and line_lost rises in the same cycle the debounced pattern becomes 0000.
- With the macro:
  - When the debounced pattern goes from non-zero to 0000, the presented pattern keeps the last non-zero value. State HOLD is entered and the hold counter counts sample ticks.
  - After LOST_HOLD ticks, the presented pattern becomes 0000, line_lost=1 and sensor_change pulses. State returns to IDLE.
  - A non-zero debounced pattern during HOLD is presented immediately, aborts HOLD (counter cleared) and pulses sensor_change only if it differs from the held value.
  - rst forces IDLE.

Test Plan:
- Bench parameters: CLK_DIV=4, DEB_LEN=3, TAIL_LEN=5, LOST_HOLD=2.
- Reset check: assert rst for 3 cycles with all raw inputs at 1 -> all outputs 0 during reset; first sample_tick appears 5 cycles after release; left_infrared_f rises on the 3rd tick with a single sensor_change pulse.
- Glitch rejection: pulse mid_left_infrared high for 2 sample periods, then low -> mid_left_infrared_f stays 0 and no sensor_change pulse.
- Simultaneous change: step all four inputs 0->1 in the same cycle -> all four outputs rise in the same cycle, exactly one sensor_change pulse, line_lost falls from 1 to 0.
- Tail: hold tail=1 for 4 ticks, 0 for 1 tick, then 1 for 5 ticks -> tail_stop rises only on the 5th tick of the second run; it stays 1 after tail returns to 0 and clears only on rst.
- Line lost without the macro: pattern 0100 -> 0000 -> line_lost=1 on the debounce edge. With LINE_LOST_HOLD_EN: outputs hold 0100 for 2 ticks, then 0000 with line_lost=1. If 0010 is re-applied mid-hold, 0010 appears after debounce, HOLD aborts and line_lost stays 0.
- Reset mid-count: raw right goes 0->1 and rst is asserted after 2 ticks -> after release, a full 3 ticks are again required before right_infrared_f=1.
